// File: rtl/sram_pkg.sv
// Shared types and default constants for the SRAM access unit.
package sram_pkg;

    localparam int SRAM_DATA_W   = 16;
    localparam int SRAM_ADDR_W   = 16;
    localparam int SRAM_WAIT_DEF = 2;

    // Access sequencer states. The two *_DONE states also accept a new request.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ACC   = 3'd1,
        RD_DONE  = 3'd2,
        WR_SETUP = 3'd3,
        WR_PULSE = 3'd4,
        WR_HOLD  = 3'd5,
        WR_DONE  = 3'd6
    } sram_state_t;

endpackage

// File: rtl/sram_access_unit_if.sv
// CPU-side bus of the SRAM access unit: register loads, access requests and
// status. The CPU/ISDU side uses the master modport, the unit uses slave.
interface sram_access_unit_if
    import sram_pkg::*;
#(
    parameter int DATA_W = SRAM_DATA_W,
    parameter int ADDR_W = SRAM_ADDR_W
);
    localparam int NLANE = DATA_W / 8;

    logic [DATA_W-1:0] Bus;
    logic              LD_MAR;
    logic              LD_MDR;
    logic              Req_Rd;
    logic              Req_Wr;
    logic [NLANE-1:0]  Byte_En;
    logic              Busy;
    logic              Done;
    logic              Err;
    logic [ADDR_W-1:0] MAR_out;
    logic [DATA_W-1:0] MDR_out;

    modport master (
        output Bus, LD_MAR, LD_MDR, Req_Rd, Req_Wr, Byte_En,
        input  Busy, Done, Err, MAR_out, MDR_out
    );

    modport slave (
        input  Bus, LD_MAR, LD_MDR, Req_Rd, Req_Wr, Byte_En,
        output Busy, Done, Err, MAR_out, MDR_out
    );

endinterface

// File: rtl/sram_wait_counter.sv
// Loadable down-counter timing the SRAM wait states. Load has priority over
// decrement, and the count stops at zero instead of wrapping.
module sram_wait_counter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               load,
    input  logic [$clog2(WAIT_CYCLES+1)-1:0]   load_val,
    input  logic                               dec,
    output logic                               zero
);
    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    // Count register: reload on state entry, otherwise count down to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/sram_access_unit.sv
// MAR/MDR pair plus a multi-cycle sequencer for an asynchronous SRAM.
// Optional feature macro: SRAM_BYTE_WRITE_EN -- when defined, writes use the
// Byte_En lanes latched with Req_Wr; otherwise writes enable every lane.
// WAIT_CYCLES must lie in 1..15.
module sram_access_unit
    import sram_pkg::*;
#(
    parameter int  DATA_W      = SRAM_DATA_W,
    parameter int  ADDR_W      = SRAM_ADDR_W,
    parameter int  WAIT_CYCLES = SRAM_WAIT_DEF,
    localparam int NLANE       = DATA_W / 8
) (
    input  logic              Clk,
    input  logic              Reset,
    sram_access_unit_if.slave cpu,
    output logic [ADDR_W-1:0] ADDR,
    inout  wire  [DATA_W-1:0] Mem_Bus,
    output logic              CE_n,
    output logic              OE_n,
    output logic              WE_n,
    output logic [NLANE-1:0]  BE_n
);
    localparam int               CNT_W   = $clog2(WAIT_CYCLES + 1);
    // RD_ACC spans WAIT_CYCLES+1 cycles, WR_PULSE spans WAIT_CYCLES cycles.
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WAIT_CYCLES - 1);

    sram_state_t       state, state_nxt;
    logic              idle_like, busy;
    logic              accept_rd, accept_wr;
    logic              err_nxt, err_q;
    logic              cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]  cnt_load_val;
    logic              ce_n_d, oe_n_d, we_n_d, drv_d, drv_q;
    logic [NLANE-1:0]  be_n_d, be_lat, be_lat_nxt, be_wr_n;
    logic [ADDR_W-1:0] mar_q, addr_q;
    logic [DATA_W-1:0] mdr_q, wdata_q;

    // States that accept a new request; every other state is an access.
    assign idle_like = (state == IDLE) || (state == RD_DONE) || (state == WR_DONE);
    assign busy      = !idle_like;
    assign accept_rd = idle_like && cpu.Req_Rd;
    assign accept_wr = idle_like && cpu.Req_Wr && !cpu.Req_Rd;

    // Illegal: read and write together, or any load/request during an access.
    assign err_nxt = (idle_like && cpu.Req_Rd && cpu.Req_Wr) ||
                     (busy && (cpu.LD_MAR || cpu.LD_MDR || cpu.Req_Rd || cpu.Req_Wr));

    assign be_lat_nxt = accept_wr ? cpu.Byte_En : be_lat;

`ifdef SRAM_BYTE_WRITE_EN
    assign be_wr_n = ~be_lat_nxt;
`else
    logic unused_byte_en;
    assign unused_byte_en = ^be_lat_nxt;
    assign be_wr_n        = '0;
`endif

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait (
        .clk      (Clk),
        .rst_n    (Reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Next-state, counter reload and next values of the registered SRAM strobes.
    always_comb begin
        state_nxt    = state;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        ce_n_d       = 1'b1;
        oe_n_d       = 1'b1;
        we_n_d       = 1'b1;
        drv_d        = 1'b0;
        be_n_d       = '1;

        case (state)
            IDLE, RD_DONE, WR_DONE: begin
                if (accept_rd)      state_nxt = RD_ACC;
                else if (accept_wr) state_nxt = WR_SETUP;
                else                state_nxt = IDLE;
            end
            RD_ACC:   if (cnt_zero) state_nxt = RD_DONE;
            WR_SETUP: state_nxt = WR_PULSE;
            WR_PULSE: if (cnt_zero) state_nxt = WR_HOLD;
            WR_HOLD:  state_nxt = WR_DONE;
            default:  state_nxt = IDLE;
        endcase

        cnt_load = (state_nxt != state);
        if (state_nxt == RD_ACC)        cnt_load_val = RD_LOAD;
        else if (state_nxt == WR_PULSE) cnt_load_val = WR_LOAD;

        case (state_nxt)
            RD_ACC: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                be_n_d = '0;
            end
            WR_SETUP, WR_HOLD: begin
                ce_n_d = 1'b0;
                drv_d  = 1'b1;
                be_n_d = be_wr_n;
            end
            WR_PULSE: begin
                ce_n_d = 1'b0;
                we_n_d = 1'b0;
                drv_d  = 1'b1;
                be_n_d = be_wr_n;
            end
            default: ;
        endcase
    end

    assign cnt_dec = (state == RD_ACC) || (state == WR_PULSE);

    // State register and registered SRAM strobes, so the strobes never glitch.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            err_q <= 1'b0;
            CE_n  <= 1'b1;
            OE_n  <= 1'b1;
            WE_n  <= 1'b1;
            BE_n  <= '1;
            drv_q <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= err_nxt;
            CE_n  <= ce_n_d;
            OE_n  <= oe_n_d;
            WE_n  <= we_n_d;
            BE_n  <= be_n_d;
            drv_q <= drv_d;
        end
    end

    // MAR/MDR and the access address. A request snapshots the pre-load MAR, so a
    // same-cycle LD_MAR updates MAR but not the address of the starting access.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            mar_q  <= '0;
            mdr_q  <= '0;
            addr_q <= '0;
        end else begin
            if (!busy && cpu.LD_MAR) mar_q <= cpu.Bus[ADDR_W-1:0];

            if (state == RD_ACC && cnt_zero) mdr_q <= Mem_Bus;
            else if (!busy && cpu.LD_MDR)    mdr_q <= cpu.Bus;

            if (accept_rd || accept_wr)   addr_q <= mar_q;
            else if (!busy && cpu.LD_MAR) addr_q <= cpu.Bus[ADDR_W-1:0];
        end
    end

    // Write data and lane enables captured when a write is accepted.
    always_ff @(posedge Clk) begin
        be_lat <= be_lat_nxt;
        if (accept_wr) wdata_q <= mdr_q;
    end

    assign Mem_Bus     = drv_q ? wdata_q : 'z;
    assign ADDR        = addr_q;
    assign cpu.Busy    = busy;
    assign cpu.Done    = (state == RD_DONE) || (state == WR_DONE);
    assign cpu.Err     = err_q;
    assign cpu.MAR_out = mar_q;
    assign cpu.MDR_out = mdr_q;

endmodule

// File: tb/tb_sram_access_unit.sv
// Bench for sram_access_unit: a vector table of single accesses against an
// SRAM model with a completion scoreboard, plus hand-written corner sequences.
module tb_sram_access_unit;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Unit under test with WAIT_CYCLES=2 and an SRAM model
    sram_access_unit_if #(.DATA_W(16), .ADDR_W(16)) cpu0 ();
    wire  [15:0] mem_bus0;
    logic [15:0] addr0;
    logic        ce0_n, oe0_n, we0_n;
    logic [1:0]  be0_n;

    sram_access_unit #(.DATA_W(16), .ADDR_W(16), .WAIT_CYCLES(2)) dut0 (
        .Clk(clk), .Reset(rst_n), .cpu(cpu0), .ADDR(addr0), .Mem_Bus(mem_bus0),
        .CE_n(ce0_n), .OE_n(oe0_n), .WE_n(we0_n), .BE_n(be0_n)
    );

    logic [15:0] mem [0:65535];
    assign mem_bus0 = (!ce0_n && !oe0_n) ? mem[addr0] : 16'hzzzz;

    always @(posedge we0_n) begin
        if (!ce0_n) begin
            for (int l = 0; l < 2; l++)
                if (!be0_n[l]) mem[addr0][8*l +: 8] = mem_bus0[8*l +: 8];
        end
    end

    // Second unit with WAIT_CYCLES=1; its SRAM always reads 0xA5A5
    sram_access_unit_if #(.DATA_W(16), .ADDR_W(16)) cpu1 ();
    wire  [15:0] mem_bus1;
    logic [15:0] addr1;
    logic        ce1_n, oe1_n, we1_n;
    logic [1:0]  be1_n;

    sram_access_unit #(.DATA_W(16), .ADDR_W(16), .WAIT_CYCLES(1)) dut1 (
        .Clk(clk), .Reset(rst_n), .cpu(cpu1), .ADDR(addr1), .Mem_Bus(mem_bus1),
        .CE_n(ce1_n), .OE_n(oe1_n), .WE_n(we1_n), .BE_n(be1_n)
    );

    assign mem_bus1 = (!ce1_n && !oe1_n) ? 16'hA5A5 : 16'hzzzz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard of outstanding accesses on dut0
    typedef struct {
        logic        rd;
        logic [15:0] addr;
        logic [15:0] data;
        logic [1:0]  ben;
        int          oe_cnt;
        int          we_cnt;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    int          oe_lo = 0;
    int          we_lo = 0;
    logic [1:0]  be_seen = 2'b11;

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst_n) begin
            sbq.delete();
            oe_lo   = 0;
            we_lo   = 0;
            be_seen = 2'b11;
        end else begin
            if (!oe0_n) oe_lo++;
            if (!we0_n) we_lo++;
            if (!ce0_n) be_seen = be0_n;
            if (cpu0.Done) begin
                if (sbq.size() == 0) begin
                    check("done_without_request", {31'd0, cpu0.Done}, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    if (e.rd) check("read_mdr", {16'd0, cpu0.MDR_out}, {16'd0, e.data});
                    else      check("write_mem", {16'd0, mem[e.addr]}, {16'd0, e.data});
                    check("oe_low_cycles", oe_lo, e.oe_cnt);
                    check("we_low_cycles", we_lo, e.we_cnt);
                    check("be_n_during_access", {30'd0, be_seen}, {30'd0, e.ben});
                end
                oe_lo   = 0;
                we_lo   = 0;
                be_seen = 2'b11;
            end
        end
    end

    task automatic push_exp(input logic rd, input logic [15:0] addr, input logic [15:0] data,
                            input logic [1:0] ben);
        exp_t e;
        e.rd     = rd;
        e.addr   = addr;
        e.data   = data;
        e.ben    = ben;
        e.oe_cnt = rd ? 3 : 0;
        e.we_cnt = rd ? 0 : 2;
        // request driven at cycle cyc, sampled at the next edge (E0);
        // read Done follows E3, write Done follows E4
        e.cyc    = cyc + (rd ? 4 : 5);
        sbq.push_back(e);
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = cpu0.Done;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s: Done not seen within 20 cycles", name);
        end
    endtask

    task automatic load_regs(input logic [15:0] addr, input logic [15:0] data);
        @(negedge clk);
        cpu0.Bus = addr; cpu0.LD_MAR = 1'b1;
        @(negedge clk);
        cpu0.LD_MAR = 1'b0; cpu0.Bus = data; cpu0.LD_MDR = 1'b1;
        @(negedge clk);
        cpu0.LD_MDR = 1'b0;
    endtask

    typedef struct {
        logic        rd;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [15:0] init;
        logic [15:0] exp_word;
        logic [1:0]  exp_ben;
    } vec_t;

    vec_t vt [6];

    initial begin
        int n;
        int wl;
        bit seen;

        rst_n = 1'b1;
        cpu0.Bus = '0; cpu0.LD_MAR = 0; cpu0.LD_MDR = 0; cpu0.Req_Rd = 0; cpu0.Req_Wr = 0; cpu0.Byte_En = '0;
        cpu1.Bus = '0; cpu1.LD_MAR = 0; cpu1.LD_MDR = 0; cpu1.Req_Rd = 0; cpu1.Req_Wr = 0; cpu1.Byte_En = '0;

        //                rd    addr      wdata     be     init      exp_word  exp_ben
        vt[0] = '{1'b1, 16'h3000, 16'h0000, 2'b00, 16'hBEEF, 16'hBEEF, 2'b00};
        vt[4] = '{1'b0, 16'h0043, 16'h0F0F, 2'b11, 16'h0000, 16'h0F0F, 2'b00};
        vt[5] = '{1'b1, 16'hFFFF, 16'h0000, 2'b00, 16'h8001, 16'h8001, 2'b00};
`ifdef SRAM_BYTE_WRITE_EN
        vt[1] = '{1'b0, 16'h0040, 16'h1234, 2'b10, 16'h5678, 16'h1278, 2'b01};
        vt[2] = '{1'b0, 16'h0041, 16'hABCD, 2'b01, 16'h0000, 16'h00CD, 2'b10};
        vt[3] = '{1'b0, 16'h0042, 16'hFFFF, 2'b00, 16'h1111, 16'h1111, 2'b11};
`else
        vt[1] = '{1'b0, 16'h0040, 16'h1234, 2'b10, 16'h5678, 16'h1234, 2'b00};
        vt[2] = '{1'b0, 16'h0041, 16'hABCD, 2'b01, 16'h0000, 16'hABCD, 2'b00};
        vt[3] = '{1'b0, 16'h0042, 16'hFFFF, 2'b00, 16'h1111, 16'hFFFF, 2'b00};
`endif

        // Reset state, checked before any clock edge
        #1 rst_n = 1'b0;
        #2;
        check("rst_ce_n", {31'd0, ce0_n}, 32'd1);
        check("rst_oe_n", {31'd0, oe0_n}, 32'd1);
        check("rst_we_n", {31'd0, we0_n}, 32'd1);
        check("rst_be_n", {30'd0, be0_n}, 32'd3);
        check("rst_busy", {31'd0, cpu0.Busy}, 32'd0);
        check("rst_done", {31'd0, cpu0.Done}, 32'd0);
        check("rst_err", {31'd0, cpu0.Err}, 32'd0);
        check("rst_mar", {16'd0, cpu0.MAR_out}, 32'd0);
        check("rst_mdr", {16'd0, cpu0.MDR_out}, 32'd0);
        check("rst_ce_n_w1", {31'd0, ce1_n}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Table of single accesses
        for (int i = 0; i < 6; i++) begin
            mem[vt[i].addr] = vt[i].init;
            load_regs(vt[i].addr, vt[i].wdata);
            check("vec_mar_load", {16'd0, cpu0.MAR_out}, {16'd0, vt[i].addr});
            check("vec_addr_eq_mar", {16'd0, addr0}, {16'd0, vt[i].addr});
            check("vec_mdr_load", {16'd0, cpu0.MDR_out}, {16'd0, vt[i].wdata});
            cpu0.Req_Rd = vt[i].rd; cpu0.Req_Wr = !vt[i].rd; cpu0.Byte_En = vt[i].be;
            push_exp(vt[i].rd, vt[i].addr, vt[i].exp_word, vt[i].exp_ben);
            @(negedge clk);
            cpu0.Req_Rd = 0; cpu0.Req_Wr = 0;
            check("vec_busy", {31'd0, cpu0.Busy}, 32'd1);
            wait_done("vec_done");
        end

        // Read and write requested together: read only, one-cycle Err
        mem[16'h3000] = 16'hBEEF;
        load_regs(16'h3000, 16'h0000);
        cpu0.Req_Rd = 1; cpu0.Req_Wr = 1; cpu0.Byte_En = 2'b11;
        push_exp(1'b1, 16'h3000, 16'hBEEF, 2'b00);
        @(negedge clk);
        cpu0.Req_Rd = 0; cpu0.Req_Wr = 0;
        check("both_err_pulse", {31'd0, cpu0.Err}, 32'd1);
        @(negedge clk);
        check("both_err_clear", {31'd0, cpu0.Err}, 32'd0);
        wait_done("both_done");

        // LD_MAR during RD_ACC is ignored and flagged
        load_regs(16'h3000, 16'h0000);
        cpu0.Req_Rd = 1;
        push_exp(1'b1, 16'h3000, 16'hBEEF, 2'b00);
        @(negedge clk);
        cpu0.Req_Rd = 0; cpu0.Bus = 16'hFFFF; cpu0.LD_MAR = 1;
        @(negedge clk);
        cpu0.LD_MAR = 0;
        check("busy_load_err", {31'd0, cpu0.Err}, 32'd1);
        check("busy_load_mar_kept", {16'd0, cpu0.MAR_out}, 32'h3000);
        @(negedge clk);
        check("busy_load_err_clear", {31'd0, cpu0.Err}, 32'd0);
        wait_done("busy_load_done");
        check("busy_load_addr", {16'd0, addr0}, 32'h3000);

        // Reset asserted mid-WR_PULSE, between clock edges
        mem[16'h0500] = 16'h0000;
        load_regs(16'h0500, 16'hC3C3);
        cpu0.Req_Wr = 1; cpu0.Byte_En = 2'b11;
        @(negedge clk);
        cpu0.Req_Wr = 0;
        check("wr_setup_bus_driven", {16'd0, mem_bus0}, 32'h0000C3C3);
        @(negedge clk);
        check("wr_pulse_we_low", {31'd0, we0_n}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_we_n", {31'd0, we0_n}, 32'd1);
        check("midrst_ce_n", {31'd0, ce0_n}, 32'd1);
        check("midrst_mar", {16'd0, cpu0.MAR_out}, 32'd0);
        check("midrst_mdr", {16'd0, cpu0.MDR_out}, 32'd0);
        check("midrst_busy", {31'd0, cpu0.Busy}, 32'd0);
        checks++;
        if (mem_bus0 === 16'hC3C3) begin
            failures++;
            $display("FAIL midrst_bus_released: got %h, expected bus not driven", mem_bus0);
        end
        @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // WAIT_CYCLES=1: read, then a write requested in the RD_DONE cycle
        @(negedge clk);
        n = cyc;
        cpu1.Req_Rd = 1;
        @(negedge clk);
        cpu1.Req_Rd = 0;
        seen = cpu1.Done;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = cpu1.Done;
        end
        check("b2b_first_done_seen", {31'd0, seen}, 32'd1);
        check("b2b_read_done_cycle", cyc - n, 32'd3);
        check("b2b_read_mdr", {16'd0, cpu1.MDR_out}, 32'h0000A5A5);
        cpu1.Req_Wr = 1; cpu1.Byte_En = 2'b11;
        @(negedge clk);
        cpu1.Req_Wr = 0;
        check("b2b_wr_setup_busy", {31'd0, cpu1.Busy}, 32'd1);
        check("b2b_wr_setup_ce_n", {31'd0, ce1_n}, 32'd0);
        check("b2b_wr_setup_we_n", {31'd0, we1_n}, 32'd1);
        wl = 0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (!we1_n) wl++;
            seen = cpu1.Done;
        end
        check("b2b_second_done_seen", {31'd0, seen}, 32'd1);
        // second Done is high in cycle 7 after the first request was driven
        check("b2b_write_done_cycle", cyc - n, 32'd7);
        check("b2b_we_low_cycles", wl, 32'd1);

        @(negedge clk);
        check("scoreboard_empty", sbq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_access_unit.md
# sram_access_unit

Parametrised successor to the datapath's MAR/MDR pair. It owns the memory address register, the memory data register, a multi-cycle SRAM read/write sequencer with configurable wait states, and per-byte lane enables. It sits between the CPU bus (loads MAR/MDR from the bus, presents MDR for gating onto it) and the external asynchronous SRAM. The ISDU issues one request and waits for `done`, replacing fixed wait states in the control FSM.

## Interface
- DATA_W, 16, data width; multiple of 8
- ADDR_W, 16, SRAM address width
- WAIT_CYCLES, 2, SRAM access wait states; legal range 1..15
- NLANE, DATA_W/8, derived, byte lanes
- Clk  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Bus  in  DATA_W  CPU bus value
- LD_MAR  in  1  load MAR from Bus[ADDR_W-1:0]
- LD_MDR  in  1  load MDR from Bus
- Req_Rd  in  1  start SRAM read at MAR into MDR
- Req_Wr  in  1  start SRAM write of MDR to MAR
- Byte_En  in  NLANE  lanes to write; sampled with Req_Wr
- Busy  out  1  access in progress
- Done  out  1  one-cycle completion pulse
- Err  out  1  one-cycle pulse on illegal request
- MAR_out  out  ADDR_W  MAR contents
- MDR_out  out  DATA_W  MDR contents
- ADDR  out  ADDR_W  SRAM address; equals MAR_out
- Mem_Bus  inout  DATA_W  SRAM data
- CE_n, OE_n, WE_n  out  1 each  SRAM strobes, active-low
- BE_n  out  NLANE  SRAM lane enables, active-low. Lane 0 is the low byte; for NLANE=2 these are LB/UB.

## Operation
- States: IDLE, RD_ACC, RD_DONE, WR_SETUP, WR_PULSE, WR_HOLD, WR_DONE.
- IDLE:
  - Req_Rd goes to RD_ACC.
  - Req_Wr goes to WR_SETUP; Byte_En is latched.
  - Req_Rd and Req_Wr together: the read wins, the write is dropped, and Err pulses.
- RD_ACC:
  - Lasts WAIT_CYCLES+1 cycles.
  - CE_n=0, OE_n=0, BE_n all 0.
  - On its last edge, MDR is loaded from Mem_Bus. Next state is RD_DONE.
- WR_SETUP: 1 cycle. CE_n=0, WE_n=1, Mem_Bus driven with MDR, BE_n set to the inverted latched lanes.
- WR_PULSE: WAIT_CYCLES cycles with WE_n=0. Everything else as in WR_SETUP.
- WR_HOLD: 1 cycle with WE_n=1. Data is still driven and CE_n is still 0.
- RD_DONE / WR_DONE:
  - 1 cycle with Done=1, Busy=0, all strobes deasserted.
  - Returns to IDLE.
  - A new request is accepted in this cycle; the next access starts directly.
- Busy=1 in every state except IDLE and *_DONE.
- Mem_Bus is high-Z in all states except WR_SETUP, WR_PULSE and WR_HOLD.
- LD_MAR/LD_MDR:
  - Honoured only when Busy=0.
  - While Busy=1 they are ignored and Err pulses.
  - A request in the same cycle as a load uses the pre-load register value.
- Requests while Busy=1 are ignored and Err pulses.
- Wait counter width is $clog2(WAIT_CYCLES+1). It reloads on every state entry and never wraps.
- All SRAM-side outputs are registered, so strobes are glitch-free.

## Timing
- Reset asserted, in any state: immediately FSM=IDLE, MAR=0, MDR=0, Busy=Done=Err=0, CE_n=OE_n=WE_n=1, BE_n all 1, Mem_Bus high-Z. An access aborted mid-write leaves SRAM contents undefined.
- Read:
  - Request sampled at edge E0.
  - Strobes are low from E0 to E(W+1).
  - MDR is valid after E(W+1).
  - Done is high from E(W+1) to E(W+2).
  - Read latency is W+2 cycles.
- Write:
  - Request sampled at E0.
  - WE_n is low from E1 to E(W+1).
  - Done is high from E(W+2) to E(W+3).
  - Write latency is W+3 cycles.
- Err is high for exactly one cycle after the offending edge.

## Configuration
- SRAM_BYTE_WRITE_EN defined: writes honour the latched Byte_En. A Byte_En of all zeros still runs the full write sequence with BE_n all 1.
- SRAM_BYTE_WRITE_EN undefined:
  - The Byte_En port is still present but ignored.
  - Writes drive BE_n all 0.
  - Reads always drive BE_n all 0 regardless of the macro.

## Structure
- Package `sram_pkg` holds:
  - the state enum `sram_state_t`
  - default constants SRAM_DATA_W=16, SRAM_ADDR_W=16, SRAM_WAIT_DEF=2
- Sub-module `sram_wait_counter` is a loadable down-counter with a zero flag. It is parameterised by WAIT_CYCLES and reset by the same async active-low Reset.

## Test plan
- Reset mid-WR_PULSE → WE_n=1, CE_n=1, Mem_Bus high-Z, MAR=0, MDR=0 within the reset-asserted cycle, with no clock edge needed.
- Read, default parameters:
  - Stimulus: Bus=0x3000 with LD_MAR; SRAM model holds 0xBEEF at 0x3000; Req_Rd.
  - Response: OE_n low for 3 cycles, Done at E3→E4, MDR_out=0xBEEF.
- Write, macro defined:
  - Stimulus: MDR=0x1234, MAR=0x0040, Byte_En=2'b10, Req_Wr.
  - Response: WE_n low for exactly 2 cycles, BE_n=2'b01, model word 0x0040 upper byte=0x12 and lower byte unchanged, Done at E4.
- Req_Rd and Req_Wr together in IDLE → read sequence only, Err high for 1 cycle, WE_n stays 1.
- LD_MAR with Bus=0xFFFF during RD_ACC → MAR unchanged, Err pulse, read completes at the original address.
- WAIT_CYCLES=1: back-to-back read then write, with Req_Wr asserted in the RD_DONE cycle → WR_SETUP begins next cycle; total 3+4=7 cycles from first request to second Done.
